compare_bank: RTL and testbench

Multi-channel, parametrised successor to the single registered A-versus-B comparator. Each channel compares a value A against a value B in one of four selectable modes. A persistence filter then decides the channel's `press` output, which flips only after the compare result has held for HOLD consecutive cycles. The block also raises per-channel rise/fall pulses and reports the first channel to assert. It sits between the switch/LFSR sources and the game/score logic.

---
 rtl/compare_bank.sv | 145 ++++++++++++++
 tb/tb_compare_bank.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/compare_bank.sv
// compare_bank: per-channel A/B comparator with a HOLD-sample persistence filter,
// rise/fall pulses and lowest-index winner report. Optional hysteresis: COMPARATOR_HYST_EN.
module compare_bank #(
    parameter int               WIDTH    = 10,
    parameter int               CHANNELS = 4,
    parameter int               HOLD     = 3,
    parameter logic [WIDTH-1:0] HYST     = WIDTH'(4)
) (
    input  logic                           Clock,
    input  logic                           reset,
    input  logic                           en,
    input  logic [2*CHANNELS-1:0]          mode,
    input  logic [WIDTH*CHANNELS-1:0]      A,
    input  logic [WIDTH*CHANNELS-1:0]      B,
    output logic [CHANNELS-1:0]            press,
    output logic [CHANNELS-1:0]            rise,
    output logic [CHANNELS-1:0]            fall,
    output logic                           win_valid,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] win_id
);

    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CW = $clog2(HOLD + 1);
    localparam logic [CW:0] HOLD_V = (CW + 1)'(HOLD);

    // Output protocol: rise/fall/win_valid are single-cycle strobes with no
    // backpressure; win_id is qualified by win_valid and holds otherwise.

    function automatic logic plain_cmp(input logic [1:0] m,
                                       input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b);
        logic r;
        case (m)
            2'b00:   r = (a > b);
            2'b01:   r = (a >= b);
            2'b10:   r = (a < b);
            default: r = (a == b);
        endcase
        return r;
    endfunction

    logic [CHANNELS-1:0] cmp_d;
    logic [CHANNELS-1:0] cmp_q;
    logic [CW-1:0]       cnt   [CHANNELS];
    logic [CW-1:0]       cnt_n [CHANNELS];
    logic [CHANNELS-1:0] press_n;
    logic [CHANNELS-1:0] rise_n;
    logic [CHANNELS-1:0] fall_n;
    logic [IW-1:0]       first_id;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [1:0]       m;
        logic             hit;

        assign a = A[WIDTH*g +: WIDTH];
        assign b = B[WIDTH*g +: WIDTH];
        assign m = mode[2*g +: 2];

`ifdef COMPARATOR_HYST_EN
        // One extra bit so A+HYST and B+HYST never wrap.
        logic [WIDTH:0] a_x, b_x, a_h, b_h, diff;
        assign a_x  = {1'b0, a};
        assign b_x  = {1'b0, b};
        assign a_h  = a_x + {1'b0, HYST};
        assign b_h  = b_x + {1'b0, HYST};
        assign diff = (a_x >= b_x) ? (a_x - b_x) : (b_x - a_x);

        always_comb begin
            hit = plain_cmp(m, a, b);
            if (press[g]) begin
                case (m)
                    2'b00:   hit = (a_h > b_x);
                    2'b01:   hit = (a_h >= b_x);
                    2'b10:   hit = (a_x < b_h);
                    default: hit = (diff <= {1'b0, HYST});
                endcase
            end
        end
`else
        always_comb hit = plain_cmp(m, a, b);
`endif

        assign cmp_d[g] = hit;
    end

`ifndef COMPARATOR_HYST_EN
    logic [WIDTH-1:0] unused_hyst;
    assign unused_hyst = HYST;
`endif

    // Persistence filter: press flips on the HOLD-th consecutive disagreeing sample.
    always_comb begin
        press_n = press;
        rise_n  = '0;
        fall_n  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_n[i] = cnt[i];
            if (cmp_q[i] == press[i]) begin
                cnt_n[i] = '0;
            end else if (({1'b0, cnt[i]} + 1'b1) == HOLD_V) begin
                press_n[i] = cmp_q[i];
                rise_n[i]  = cmp_q[i];
                fall_n[i]  = ~cmp_q[i];
                cnt_n[i]   = '0;
            end else begin
                cnt_n[i] = cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        first_id = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (rise_n[i]) first_id = IW'(i);
        end
    end

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            cmp_q     <= '0;
            press     <= '0;
            rise      <= '0;
            fall      <= '0;
            win_valid <= 1'b0;
            win_id    <= '0;
            for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
        end else if (en) begin
            cmp_q     <= cmp_d;
            press     <= press_n;
            rise      <= rise_n;
            fall      <= fall_n;
            win_valid <= |rise_n;
            if (|rise_n) win_id <= first_id;
            for (int i = 0; i < CHANNELS; i++) cnt[i] <= cnt_n[i];
        end else begin
            // Frozen: state holds, strobes drop.
            rise      <= '0;
            fall      <= '0;
            win_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_compare_bank.sv
// Directed testbench for compare_bank (WIDTH=10, CHANNELS=4, HOLD=3, HYST=4).
// Driver pushes hand-computed per-edge expectations; a negedge monitor pops and compares.
module tb_compare_bank;

    localparam int WIDTH    = 10;
    localparam int CHANNELS = 4;
    localparam int HOLD     = 3;

    localparam logic [1:0] GT = 2'b00;
    localparam logic [1:0] GE = 2'b01;
    localparam logic [1:0] LT = 2'b10;
    localparam logic [1:0] EQ = 2'b11;

    logic                      Clock;
    logic                      reset;
    logic                      en;
    logic [2*CHANNELS-1:0]     mode;
    logic [WIDTH*CHANNELS-1:0] A;
    logic [WIDTH*CHANNELS-1:0] B;
    logic [CHANNELS-1:0]       press;
    logic [CHANNELS-1:0]       rise;
    logic [CHANNELS-1:0]       fall;
    logic                      win_valid;
    logic [1:0]                win_id;

    // expectation word: {press, rise, fall, win_valid, win_id}
    logic [14:0] exp_q[$];
    string       tag_q[$];
    string       scen;
    int          checks = 0;
    int          errors = 0;
    int          step_n = 0;

    compare_bank #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .HOLD(HOLD), .HYST(10'd4)
    ) dut (
        .Clock(Clock), .reset(reset), .en(en), .mode(mode), .A(A), .B(B),
        .press(press), .rise(rise), .fall(fall),
        .win_valid(win_valid), .win_id(win_id)
    );

    // clock/reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got press=%b rise=%b fall=%b wv=%b id=%0d, expected press=%b rise=%b fall=%b wv=%b id=%0d",
                     name, act[14:11], act[10:7], act[6:3], act[2], act[1:0],
                     exp[14:11], exp[10:7], exp[6:3], exp[2], exp[1:0]);
        end
    endtask

    // monitor
    always @(negedge Clock) begin
        if (exp_q.size() != 0) begin
            logic [14:0] e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, {press, rise, fall, win_valid, win_id}, e);
        end
    end

    // driver tasks
    task automatic set_ch(input int i, input logic [1:0] m,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        mode[2*i +: 2]     = m;
        A[WIDTH*i +: WIDTH] = a;
        B[WIDTH*i +: WIDTH] = b;
    endtask

    task automatic idle_all();
        for (int i = 0; i < CHANNELS; i++) set_ch(i, GT, 10'h000, 10'h3FF);
    endtask

    task automatic step(input logic [3:0] p, input logic [3:0] r, input logic [3:0] f,
                        input logic wv, input logic [1:0] id);
        @(posedge Clock);
        step_n++;
        exp_q.push_back({p, r, f, wv, id});
        tag_q.push_back($sformatf("%s_edge%0d", scen, step_n));
        @(negedge Clock);
    endtask

    task automatic quiet(input int n, input logic [3:0] p, input logic [1:0] id);
        for (int k = 0; k < n; k++) step(p, 4'h0, 4'h0, 1'b0, id);
    endtask

    initial begin
        reset = 1'b0;
        en    = 1'b1;
        mode  = '0;
        A     = '0;
        B     = '0;

        // 1: reset held with every channel qualifying
        for (int i = 0; i < CHANNELS; i++) set_ch(i, GT, 10'h3E0, 10'h082);
        repeat (2) @(negedge Clock);
        check("reset_hold", {press, rise, fall, win_valid, win_id}, 15'h0);
        reset = 1'b1;
        scen = "release"; step_n = 0;
        quiet(3, 4'h0, 2'd0);
        step(4'hF, 4'hF, 4'h0, 1'b1, 2'd0);
        idle_all();
        quiet(3, 4'hF, 2'd0);
        step(4'h0, 4'h0, 4'hF, 1'b0, 2'd0);

        // 2: ch0 GT
        scen = "gt_ch0"; step_n = 0;
        set_ch(0, GT, 10'h3E0, 10'h082);
        quiet(3, 4'h0, 2'd0);
        step(4'h1, 4'h1, 4'h0, 1'b1, 2'd0);
        idle_all();
        quiet(3, 4'h1, 2'd0);
        step(4'h0, 4'h0, 4'h1, 1'b0, 2'd0);

        // 3: two-sample glitch is filtered out
        scen = "glitch"; step_n = 0;
        set_ch(0, GT, 10'h3E0, 10'h082);
        quiet(2, 4'h0, 2'd0);
        set_ch(0, GT, 10'h001, 10'h002);
        quiet(6, 4'h0, 2'd0);
        idle_all();

        // 4: simultaneous EQ on ch1 and ch3
        scen = "eq_tie"; step_n = 0;
        set_ch(1, EQ, 10'h200, 10'h200);
        set_ch(3, EQ, 10'h200, 10'h200);
        quiet(3, 4'h0, 2'd0);
        step(4'hA, 4'hA, 4'h0, 1'b1, 2'd1);
        idle_all();
        quiet(3, 4'hA, 2'd1);
        step(4'h0, 4'h0, 4'hA, 1'b0, 2'd1);

        // 5: ch2 LT with en gap mid-count, then en=0 right after the flip
        scen = "en_gap"; step_n = 0;
        set_ch(2, LT, 10'h010, 10'h020);
        quiet(3, 4'h0, 2'd1);
        en = 1'b0;
        quiet(5, 4'h0, 2'd1);
        en = 1'b1;
        step(4'h4, 4'h4, 4'h0, 1'b1, 2'd2);
        en = 1'b0;
        step(4'h4, 4'h0, 4'h0, 1'b0, 2'd2);
        en = 1'b1;
        idle_all();
        quiet(3, 4'h4, 2'd2);
        step(4'h0, 4'h0, 4'h4, 1'b0, 2'd2);

        // 7: all four modes on equal operands: GE and EQ true, GT and LT false
        scen = "modes_eq"; step_n = 0;
        set_ch(0, GE, 10'h155, 10'h155);
        set_ch(1, LT, 10'h155, 10'h155);
        set_ch(2, GT, 10'h155, 10'h155);
        set_ch(3, EQ, 10'h155, 10'h155);
        quiet(3, 4'h0, 2'd2);
        step(4'h9, 4'h9, 4'h0, 1'b1, 2'd0);
        idle_all();
        quiet(3, 4'h9, 2'd0);
        step(4'h0, 4'h0, 4'h9, 1'b0, 2'd0);

        // 6: small dip below B while pressed
        scen = "hyst"; step_n = 0;
        set_ch(0, GT, 10'h101, 10'h100);
        quiet(3, 4'h0, 2'd0);
        step(4'h1, 4'h1, 4'h0, 1'b1, 2'd0);
        set_ch(0, GT, 10'h0FE, 10'h100);
`ifdef COMPARATOR_HYST_EN
        quiet(5, 4'h1, 2'd0);
        set_ch(0, GT, 10'h0FC, 10'h100);
`endif
        quiet(3, 4'h1, 2'd0);
        step(4'h0, 4'h0, 4'h1, 1'b0, 2'd0);
        idle_all();

        // 8: asynchronous reset while pressed and mid-count
        scen = "reset_mid"; step_n = 0;
        set_ch(3, GT, 10'h3E0, 10'h082);
        quiet(3, 4'h0, 2'd0);
        step(4'h8, 4'h8, 4'h0, 1'b1, 2'd3);
        quiet(1, 4'h8, 2'd3);
        set_ch(1, GT, 10'h3E0, 10'h082);
        quiet(2, 4'h8, 2'd3);
        #2 reset = 1'b0;
        #1 check("reset_async", {press, rise, fall, win_valid, win_id}, 15'h0);
        @(negedge Clock);
        reset = 1'b1;
        scen = "after_reset"; step_n = 0;
        quiet(3, 4'h0, 2'd0);
        step(4'hA, 4'hA, 4'h0, 1'b1, 2'd1);

        @(negedge Clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
